mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of address, read data and write data buses.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-low.
REQ-004 Port: inst_req_valid / inst_req_ready  in / out  1 / 1  instruction fetch request handshake (read-only requester, port 0).
REQ-005 Port: inst_addr  in  DATA_W  fetch address.
REQ-006 Port: inst_rdata / inst_rvalid / inst_rready  out / out / in  DATA_W / 1 / 1  fetch response channel.
REQ-007 Port: data_req_valid / data_req_ready  in / out  1 / 1  data request handshake (port 1).
REQ-008 Port: data_wen  in  1  1 = write, 0 = read; sampled with request.
REQ-009 Port: data_addr / data_wdata / data_wstrb  in  DATA_W / DATA_W / 4  data request fields.
REQ-010 Port: data_rdata / data_rvalid / data_rready  out / out / in  DATA_W / 1 / 1  data read response channel.
REQ-011 Port: mem_req_valid / mem_req_ready  out / in  1 / 1  unified memory request handshake.
REQ-012 Port: mem_wen, mem_addr, mem_wdata, mem_wstrb  out  1 / DATA_W / DATA_W / 4  latched request fields.
REQ-013 Port: mem_rdata / mem_rvalid / mem_rready  in / in / out  DATA_W / 1 / 1  unified read response.
REQ-014 Port: conflict_cnt  out  32  stall-cycle performance counter.

Function
REQ-015 FSM states: IDLE, REQ, RESP; one owner register (0 = inst, 1 = data), one last_grant register.
REQ-016 IDLE, one requester valid: grant it; assert its req_ready combinationally that cycle; latch addr/wdata/wstrb/wen (inst: wen = 0, wstrb = 0); go REQ.
REQ-017 IDLE, both valid: grant the port not equal to last_grant; last_grant <= granted port on every grant.
REQ-018 req_ready SHALL be 0 for both ports in REQ and RESP; requests held valid wait.
REQ-019 REQ: mem_req_valid = 1 with latched fields stable until mem_req_ready; on acceptance, write -> IDLE, read -> RESP.
REQ-020 RESP: mem_rready = owner's rready; owner's rvalid = mem_rvalid; owner's rdata = mem_rdata; non-owner rvalid = 0.
REQ-021 RESP exits to IDLE on the cycle mem_rvalid and owner rready are both 1.
REQ-022 Latency: accept cycle T; mem_req_valid from T+1; earliest new grant T+2 after a write with mem_req_ready = 1 at T+1.
REQ-023 conflict_cnt SHALL increment by 1 per cycle per requester that asserts req_valid without req_ready (max +2 per cycle), saturating at 0xFFFFFFFF.
REQ-024 No combinational path from mem-side inputs to any req_ready; mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb are registers.
REQ-025 Writes never produce responses; the data port's rvalid stays 0 for writes.

Reset
REQ-026 rst low at any time, including mid-REQ or mid-RESP: state <= IDLE, owner <= 0, last_grant <= 0 (first conflict goes to data), conflict_cnt <= 0.
REQ-027 During reset, all outputs SHALL be 0, including all ready/valid signals and the latched fields.
REQ-028 A read pending at reset is dropped; no rvalid is forwarded after reset release.

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold the state encoding, port-id constants (PORT_INST = 0, PORT_DATA = 1) and the DATA_W default.
REQ-030 One sub-module, arb_rr2 (2-way round-robin picker: two valids plus last_grant in; grant one-hot out), is natural; everything else stays flat.

Verification
REQ-031 Inst read alone: addr 0x100, mem_req_ready = 1, mem_rvalid with 0xDEADBEEF one cycle later -> inst_rvalid = 1, inst_rdata = 0xDEADBEEF; data_rvalid = 0; conflict_cnt = 0.
REQ-032 Simultaneous first requests after reset (inst 0x0, data write 0x200 / 0x12345678 / strb 0xF) -> data granted first, then inst; conflict_cnt advances once per waiting cycle.
REQ-033 Backpressure: mem_req_ready low for 5 cycles in REQ -> mem_addr, mem_wdata and mem_wstrb stay constant; no req_ready asserted.
REQ-034 Response stall: data read, mem_rvalid = 1 while data_rready = 0 for 3 cycles -> FSM stays in RESP; exactly one transfer when data_rready rises.
REQ-035 rst low mid-RESP -> all outputs 0 immediately; after release, a fresh inst request is granted from IDLE and no stale rvalid is seen.
REQ-036 Counter saturation: preload conflict_cnt to 0xFFFFFFFE, hold both ports stalled -> reads 0xFFFFFFFF and holds there.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester port ids and default bus widths.
package mem_arb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned CNT_W      = 32;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of all arbiter-facing handshake and bus signals.
//   inst_*  : read-only fetch requester (port 0) and its response channel
//   data_*  : read/write data requester (port 1) and its read response channel
//   mem_*   : unified memory request and read response channels
//   conflict_cnt : stall-cycle performance counter
// slave  = arbiter side, master = requesters + memory side.
interface mem_arbiter_if #(
    parameter int unsigned DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic                                inst_req_valid;
    logic                                inst_req_ready;
    logic [DATA_W-1:0]                   inst_addr;
    logic [DATA_W-1:0]                   inst_rdata;
    logic                                inst_rvalid;
    logic                                inst_rready;

    logic                                data_req_valid;
    logic                                data_req_ready;
    logic                                data_wen;
    logic [DATA_W-1:0]                   data_addr;
    logic [DATA_W-1:0]                   data_wdata;
    logic [mem_arb_pkg::STRB_W-1:0]      data_wstrb;
    logic [DATA_W-1:0]                   data_rdata;
    logic                                data_rvalid;
    logic                                data_rready;

    logic                                mem_req_valid;
    logic                                mem_req_ready;
    logic                                mem_wen;
    logic [DATA_W-1:0]                   mem_addr;
    logic [DATA_W-1:0]                   mem_wdata;
    logic [mem_arb_pkg::STRB_W-1:0]      mem_wstrb;
    logic [DATA_W-1:0]                   mem_rdata;
    logic                                mem_rvalid;
    logic                                mem_rready;

    logic [mem_arb_pkg::CNT_W-1:0]       conflict_cnt;

    modport slave (
        input  inst_req_valid, inst_addr, inst_rready,
        input  data_req_valid, data_wen, data_addr, data_wdata, data_wstrb, data_rready,
        input  mem_req_ready, mem_rdata, mem_rvalid,
        output inst_req_ready, inst_rdata, inst_rvalid,
        output data_req_ready, data_rdata, data_rvalid,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb, mem_rready,
        output conflict_cnt
    );

    modport master (
        output inst_req_valid, inst_addr, inst_rready,
        output data_req_valid, data_wen, data_addr, data_wdata, data_wstrb, data_rready,
        output mem_req_ready, mem_rdata, mem_rvalid,
        input  inst_req_ready, inst_rdata, inst_rvalid,
        input  data_req_ready, data_rdata, data_rvalid,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb, mem_rready,
        input  conflict_cnt
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
//   req_i        : request valids, bit 0 = inst, bit 1 = data
//   last_grant_i : port granted most recently (0 = inst, 1 = data)
//   grant_c_o    : one-hot combinational grant
module arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_c_o
);

    // On contention the port that did not win last time takes the grant.
    assign grant_c_o[0] = req_i[0] & (~req_i[1] |  last_grant_i);
    assign grant_c_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : all handshake/bus signals (see mem_arbiter_if)
// CNT_RST_VAL sets the counter value loaded by reset (0 in normal use).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned      DATA_W      = DEF_DATA_W,
    parameter logic [CNT_W-1:0] CNT_RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic               mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         grant_c;
    logic               inst_ready_c, data_ready_c;
    logic               mem_rready_c, inst_rvalid_c, data_rvalid_c;
    logic [DATA_W-1:0]  inst_rdata_c, data_rdata_c;
    logic [1:0]         stall_c;
    logic [CNT_W:0]     cnt_sum_c;

    arb_rr2 u_rr (
        .req_i        ({bus.data_req_valid, bus.inst_req_valid}),
        .last_grant_i (last_grant_q),
        .grant_c_o    (grant_c)
    );

    // Next-state, latched request fields and response routing.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_wen_d       = mem_wen_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wstrb_d     = mem_wstrb_q;
        inst_ready_c    = 1'b0;
        data_ready_c    = 1'b0;
        mem_rready_c    = 1'b0;
        inst_rvalid_c   = 1'b0;
        data_rvalid_c   = 1'b0;
        inst_rdata_c    = '0;
        data_rdata_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    inst_ready_c    = grant_c[PORT_INST];
                    data_ready_c    = grant_c[PORT_DATA];
                    owner_d         = grant_c[PORT_DATA];
                    last_grant_d    = grant_c[PORT_DATA];
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                    if (grant_c[PORT_DATA]) begin
                        mem_wen_d   = bus.data_wen;
                        mem_addr_d  = bus.data_addr;
                        mem_wdata_d = bus.data_wdata;
                        mem_wstrb_d = bus.data_wstrb;
                    end else begin
                        mem_wen_d   = 1'b0;
                        mem_addr_d  = bus.inst_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = mem_wen_q ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_q == PORT_DATA) begin
                    mem_rready_c  = bus.data_rready;
                    data_rvalid_c = bus.mem_rvalid;
                    data_rdata_c  = bus.mem_rdata;
                end else begin
                    mem_rready_c  = bus.inst_rready;
                    inst_rvalid_c = bus.mem_rvalid;
                    inst_rdata_c  = bus.mem_rdata;
                end
                if (bus.mem_rvalid && mem_rready_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating stall counter: one per waiting requester per cycle.
    always_comb begin
        stall_c   = 2'(bus.inst_req_valid & ~inst_ready_c)
                  + 2'(bus.data_req_valid & ~data_ready_c);
        cnt_sum_c = {1'b0, cnt_q} + (CNT_W+1)'(stall_c);
        cnt_d     = cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];
    end

    // State and latched-field registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= PORT_INST;
            last_grant_q    <= PORT_INST;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            cnt_q           <= CNT_RST_VAL;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            cnt_q           <= cnt_d;
        end
    end

    // Readies are gated by rst so a valid held during reset sees no grant.
    assign bus.inst_req_ready = inst_ready_c & rst;
    assign bus.data_req_ready = data_ready_c & rst;
    assign bus.inst_rvalid    = inst_rvalid_c;
    assign bus.inst_rdata     = inst_rdata_c;
    assign bus.data_rvalid    = data_rvalid_c;
    assign bus.data_rdata     = data_rdata_c;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wstrb      = mem_wstrb_q;
    assign bus.mem_rready     = mem_rready_c;
    assign bus.conflict_cnt   = cnt_q;

endmodule
